// File: rtl/pipe_pkg.sv
// Shared opcode constants, FSM encoding and structs for the fetch/decode slice.
package pipe_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_HALT  = 6'h3F;
   localparam logic [5:0] FN_JR    = 6'h08;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      BR_WAIT = 2'd1,
      HALT    = 2'd2
   } fsm_state_t;

   typedef struct packed {
      logic is_j;
      logic is_jr;
      logic is_br;
      logic is_halt;
   } ctl_class_t;

   typedef struct packed {
      fsm_state_t state;
      logic       br_taken;
   } fetch_dbg_t;

endpackage

// File: rtl/fetch_decode.sv
// Combinational control-flow classifier for the instruction held in IF/ID.
module fetch_decode
   import pipe_pkg::*;
(
   input  logic [5:0] op_i,
   input  logic [5:0] funct_i,
   input  logic       valid_i,
   output ctl_class_t cls_o
);

   always_comb begin
      cls_o = '0;
      // An empty IF/ID slot never classifies as control flow.
      if (valid_i) begin
         cls_o.is_j    = (op_i == OP_J);
         cls_o.is_jr   = (op_i == OP_RTYPE) && (funct_i == FN_JR);
         cls_o.is_br   = (op_i == OP_BNE);
         cls_o.is_halt = (op_i == OP_HALT);
      end
   end

endmodule

// File: rtl/fetch_ctrl_unit.sv
// IF/ID register plus the control-flow FSM that drives the PC register's redirect
// inputs; targets leave here unsummed, the PC register forms the branch sum.
module fetch_ctrl_unit
   import pipe_pkg::*;
#(
   parameter int PC_W   = 7,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   pc_in,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              stall_in,
   input  logic              jr_hazard,
   input  logic [DATA_W-1:0] rs_data,
   input  logic              z_in,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [PC_W-1:0]   ifid_pc,
   output logic              ifid_valid,
   output logic              id_issue,
   output logic              j,
   output logic              jr,
   output logic              br,
   output logic [DATA_W-1:0] j_adx,
   output logic [DATA_W-1:0] jr_adx,
   output logic [DATA_W-1:0] br_adx,
   output logic              pc_wr,
   output logic              halted,
   output fetch_dbg_t        dbg_o
);

   fsm_state_t        state_q, state_d;
   logic [DATA_W-1:0] ifid_instr_q;
   logic [PC_W-1:0]   ifid_pc_q;
   logic              ifid_valid_q;
   logic              halted_q;
   logic              halt_now;
   ctl_class_t        cls;

   fetch_decode u_dec (
      .op_i    (ifid_instr_q[31:26]),
      .funct_i (ifid_instr_q[5:0]),
      .valid_i (ifid_valid_q),
      .cls_o   (cls)
   );

   always_comb begin
      state_d  = state_q;
      pc_wr    = 1'b0;
      j        = 1'b0;
      jr       = 1'b0;
      br       = 1'b0;
      id_issue = 1'b0;
      halt_now = 1'b0;
      if (!reset) begin
         case (state_q)
            RUN: begin
               if (stall_in || (cls.is_jr && jr_hazard)) begin
                  state_d = RUN;
               end else if (cls.is_j) begin
                  j        = 1'b1;
                  pc_wr    = 1'b1;
                  id_issue = 1'b1;
               end else if (cls.is_jr) begin
                  jr       = 1'b1;
                  pc_wr    = 1'b1;
                  id_issue = 1'b1;
               end else if (cls.is_br) begin
                  // Wait one cycle so z_in is valid before redirecting.
                  state_d = BR_WAIT;
               end else if (cls.is_halt) begin
                  id_issue = 1'b1;
                  halt_now = 1'b1;
                  state_d  = HALT;
               end else begin
                  pc_wr    = 1'b1;
                  id_issue = ifid_valid_q;
               end
            end
            BR_WAIT: begin
               if (!stall_in) begin
                  br       = 1'b1;
                  pc_wr    = 1'b1;
                  id_issue = 1'b1;
                  state_d  = RUN;
               end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= RUN;
         ifid_instr_q <= '0;
         ifid_pc_q    <= '0;
         ifid_valid_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (pc_wr) begin
            ifid_instr_q <= imem_rdata;
            ifid_pc_q    <= pc_in;
            ifid_valid_q <= 1'b1;
         end
         if (halt_now) begin
            halted_q     <= 1'b1;
            ifid_valid_q <= 1'b0;
         end
      end
   end

   assign imem_addr  = pc_in;
   assign ifid_instr = ifid_instr_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_valid = ifid_valid_q;
   assign halted     = halted_q;
   assign j_adx      = {{(DATA_W-PC_W){1'b0}}, ifid_instr_q[PC_W-1:0]};
   assign jr_adx     = rs_data;
   assign br_adx     = {{(DATA_W-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

   assign dbg_o.state    = state_q;
   assign dbg_o.br_taken = br & ~z_in;

endmodule

// File: tb/tb_fetch_ctrl_unit.sv
// Bench for fetch_ctrl_unit: PC register + ROM environment, instruction-level
// reference model compared every cycle, directed literal checks, random programs.
module tb_fetch_ctrl_unit;
   import pipe_pkg::*;

   localparam int PC_W   = 7;
   localparam int DATA_W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [PC_W-1:0]   pc_in, imem_addr, ifid_pc, pc_q, br_tgt;
   logic [DATA_W-1:0] imem_rdata, rs_data, ifid_instr, j_adx, jr_adx, br_adx;
   logic              stall_in, jr_hazard, z_in, ifid_valid, id_issue;
   logic              j, jr, br, pc_wr, halted;
   fetch_dbg_t        dbg_o;

   logic [31:0] rom [0:127];
   int checks = 0;
   int failures = 0;
   logic chk_en = 1'b0;
   logic [PC_W:0] exp_q[$];

   fetch_ctrl_unit #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_in      (pc_in),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .stall_in   (stall_in),
      .jr_hazard  (jr_hazard),
      .rs_data    (rs_data),
      .z_in       (z_in),
      .ifid_instr (ifid_instr),
      .ifid_pc    (ifid_pc),
      .ifid_valid (ifid_valid),
      .id_issue   (id_issue),
      .j          (j),
      .jr         (jr),
      .br         (br),
      .j_adx      (j_adx),
      .jr_adx     (jr_adx),
      .br_adx     (br_adx),
      .pc_wr      (pc_wr),
      .halted     (halted),
      .dbg_o      (dbg_o)
   );

   // ---------------- environment: ROM and PC register ----------------
   assign imem_rdata = rom[imem_addr];
   assign br_tgt = ifid_pc + 7'd1 + br_adx[PC_W-1:0];

   always_comb begin
      pc_in = pc_q;
      if (j)                pc_in = j_adx[PC_W-1:0];
      else if (jr)          pc_in = jr_adx[PC_W-1:0];
      else if (br && !z_in) pc_in = br_tgt;
   end

   always @(posedge clk) begin
      if (reset)      pc_q <= '0;
      else if (pc_wr) pc_q <= pc_in + 7'd1;
   end

   // ---------------- reference model ----------------
   logic [31:0]     m_instr;
   logic [PC_W-1:0] m_pc, m_fetch;
   logic            m_valid, m_wait, m_halted;

   typedef struct packed {
      logic            pc_wr, j, jr, br, issue;
      logic            enter_wait, leave_wait, retire_halt;
      logic [PC_W-1:0] next_pc;
   } exp_t;

   function automatic exp_t model_eval();
      exp_t e;
      logic [5:0] op;
      logic is_j, is_jr, is_bne, is_halt;
      e = '0;
      e.next_pc = m_fetch;
      op      = m_instr[31:26];
      is_j    = m_valid && (op == 6'h02);
      is_jr   = m_valid && (op == 6'h00) && (m_instr[5:0] == 6'h08);
      is_bne  = m_valid && (op == 6'h05);
      is_halt = m_valid && (op == 6'h3F);
      if (reset || m_halted) return e;
      if (m_wait) begin
         if (!stall_in) begin
            e.br = 1'b1; e.pc_wr = 1'b1; e.issue = 1'b1; e.leave_wait = 1'b1;
            // sext(imm) mod 2^7 is just its low 7 bits.
            if (!z_in) e.next_pc = m_pc + 7'd1 + m_instr[6:0];
         end
      end else if (stall_in || (is_jr && jr_hazard)) begin
         e.pc_wr = 1'b0;
      end else if (is_j) begin
         e.j = 1'b1; e.pc_wr = 1'b1; e.issue = 1'b1; e.next_pc = m_instr[6:0];
      end else if (is_jr) begin
         e.jr = 1'b1; e.pc_wr = 1'b1; e.issue = 1'b1; e.next_pc = rs_data[6:0];
      end else if (is_bne) begin
         e.enter_wait = 1'b1;
      end else if (is_halt) begin
         e.issue = 1'b1; e.retire_halt = 1'b1;
      end else begin
         e.pc_wr = 1'b1; e.issue = m_valid;
      end
      return e;
   endfunction

   always @(posedge clk) begin
      exp_t e;
      e = model_eval();
      if (reset) begin
         m_instr = '0; m_pc = '0; m_fetch = '0;
         m_valid = 1'b0; m_wait = 1'b0; m_halted = 1'b0;
      end else begin
         if (e.pc_wr) begin
            m_instr = rom[e.next_pc];
            m_pc    = e.next_pc;
            m_valid = 1'b1;
            m_fetch = e.next_pc + 7'd1;
         end
         if (e.enter_wait) m_wait = 1'b1;
         if (e.leave_wait) m_wait = 1'b0;
         if (e.retire_halt) begin
            m_halted = 1'b1;
            m_valid  = 1'b0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         exp_t e;
         logic [PC_W:0] want_pc;
         e = model_eval();
         check("m_pc_wr", pc_wr, e.pc_wr);
         check("m_j", j, e.j);
         check("m_jr", jr, e.jr);
         check("m_br", br, e.br);
         check("m_issue", id_issue, e.issue);
         check("m_halted", halted, m_halted);
         check("m_valid", ifid_valid, m_valid);
         check("m_ifid_pc", ifid_pc, m_pc);
         check("m_ifid_instr", ifid_instr, m_instr);
         check("m_imem_addr", imem_addr, e.next_pc);
         check("m_j_adx", j_adx, {25'd0, m_instr[6:0]});
         check("m_jr_adx", jr_adx, rs_data);
         check("m_br_adx", br_adx, {{16{m_instr[15]}}, m_instr[15:0]});
         check("m_br_taken", dbg_o.br_taken, e.br && !z_in);
         check("m_onehot", $countones({j, jr, br}) <= 1, 1);
         if (reset) exp_q.delete();
         if (e.issue) exp_q.push_back({1'b0, m_pc});
         if (id_issue) begin
            want_pc = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check("issue_pc", {1'b0, ifid_pc}, want_pc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_pc(input logic [PC_W-1:0] target);
      logic found;
      found = 1'b0;
      for (int n = 0; n < 64 && !found; n++) begin
         @(negedge clk);
         found = ifid_valid && (ifid_pc == target);
      end
      check("wait_pc_reached", found, 1);
   endtask

   task automatic load_directed_rom();
      for (int a = 0; a < 128; a++) rom[a] = 32'h0;
      rom[3]  = 32'h08000014;  // J 20
      rom[20] = 32'h08000005;  // J 5
      rom[5]  = 32'h14000004;  // BNE +4
      rom[10] = 32'h08000008;  // J 8
      rom[8]  = 32'h03E00008;  // JR r31
      rom[47] = 32'h0800000C;  // J 12
      rom[12] = 32'hFC000000;  // HALT
   endtask

   task automatic load_random_rom(input bit allow_halt);
      logic [31:0] w;
      int k;
      for (int a = 0; a < 128; a++) begin
         w = $urandom;
         k = $urandom_range(0, 19);
         if (k < 3)                       w[31:26] = 6'h02;
         else if (k < 5)                  begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
         else if (k < 8)                  w[31:26] = 6'h05;
         else if (k == 8 && allow_halt)   w[31:26] = 6'h3F;
         else if (k < 12)                 w[31:26] = 6'h00;
         rom[a] = w;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      stall_in = 1'b0; jr_hazard = 1'b1; z_in = 1'b0; rs_data = 32'd47;
      reset = 1'b1;
      load_directed_rom();

      // two-cycle reset, then first fetch
      @(posedge clk); #1; chk_en = 1'b1;
      @(negedge clk);
      check("rst_pc_wr", pc_wr, 0);
      check("rst_ifid_valid", ifid_valid, 0);
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      check("post_rst_pc_wr", pc_wr, 1);
      @(negedge clk);
      check("first_ifid_pc", ifid_pc, 0);
      check("first_ifid_valid", ifid_valid, 1);

      // J 20
      wait_pc(3);
      check("j_req", j, 1);
      check("j_adx", j_adx, 20);
      check("j_pc_wr", pc_wr, 1);
      @(negedge clk);
      check("j_dest_pc", ifid_pc, 20);

      // BNE taken
      wait_pc(5);
      check("bne_hold_pc_wr", pc_wr, 0);
      check("bne_hold_br", br, 0);
      @(negedge clk);
      check("bne_br", br, 1);
      check("bne_br_adx", br_adx, 4);
      @(negedge clk);
      check("bne_taken_pc", ifid_pc, 10);

      // JR with a two-cycle hazard
      wait_pc(8);
      check("jr_haz1_jr", jr, 0);
      check("jr_haz1_pc_wr", pc_wr, 0);
      @(negedge clk);
      check("jr_haz2_jr", jr, 0);
      check("jr_haz2_pc_wr", pc_wr, 0);
      @(posedge clk); #1; jr_hazard = 1'b0;
      @(negedge clk);
      check("jr_req", jr, 1);
      check("jr_adx", jr_adx, 47);
      @(negedge clk);
      check("jr_dest_pc", ifid_pc, 47);

      // HALT
      wait_pc(12);
      check("halt_issue", id_issue, 1);
      check("halt_pc_wr", pc_wr, 0);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         check("halted_flag", halted, 1);
         check("halted_pc_wr", pc_wr, 0);
         check("halted_valid", ifid_valid, 0);
      end
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0; z_in = 1'b1;
      @(negedge clk);
      check("unhalt_state", dbg_o.state, RUN);
      check("unhalt_halted", halted, 0);

      // BNE not taken, stalled three cycles in BR_WAIT
      wait_pc(5);
      check("bne2_hold_pc_wr", pc_wr, 0);
      @(posedge clk); #1; stall_in = 1'b1;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check("brwait_stall_br", br, 0);
         check("brwait_stall_pc", ifid_pc, 5);
         check("brwait_stall_state", dbg_o.state, BR_WAIT);
      end
      @(posedge clk); #1; stall_in = 1'b0;
      @(negedge clk);
      check("brwait_release_br", br, 1);
      @(negedge clk);
      check("bne_not_taken_pc", ifid_pc, 6);

      // random programs with random hazards and occasional mid-run resets
      for (int ep = 0; ep < 8; ep++) begin
         @(posedge clk); #1;
         reset = 1'b1; stall_in = 1'b0; jr_hazard = 1'b0;
         load_random_rom(ep[0]);
         for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            stall_in  = ($urandom_range(0, 3) == 0);
            jr_hazard = ($urandom_range(0, 2) == 0);
            z_in      = 1'($urandom_range(0, 1));
            rs_data   = $urandom;
            reset     = ($urandom_range(0, 199) == 0);
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      check("issue_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
